// File: rtl/axi_stream_pattern_gen.sv
// AXI-Stream test-pattern source: counter or Galois LFSR words, bounded or free-running,
// with clean abort framing and one-shot single-beat error injection.
module axi_stream_pattern_gen #(
  parameter int DATA_BITS = 32,
  parameter int COUNT_BITS = 32,
  parameter logic [DATA_BITS-1:0] LFSR_TAPS = DATA_BITS'(32'h80200003)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_BITS-1:0]  seed,
  input  logic [COUNT_BITS-1:0] length,
  input  logic                  abort,
  input  logic                  inject_error,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_BITS-1:0]  m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] word_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_reg;
  logic                  mode_reg;
  logic [COUNT_BITS-1:0] length_reg;
  logic [DATA_BITS-1:0]  gen_reg;
  logic                  abort_pending;
  logic                  err_pending;

  logic                  hs;
  logic [DATA_BITS-1:0]  gen_next;
  logic [DATA_BITS-1:0]  seed_load;
  logic [COUNT_BITS-1:0] wc_inc;
  logic                  abort_now;
  logic                  err_now;
  logic                  last_next;

  always_comb begin
    hs = m_tvalid & m_tready;
    if (mode_reg) begin
      gen_next = gen_reg[0] ? ((gen_reg >> 1) ^ LFSR_TAPS) : (gen_reg >> 1);
    end else begin
      gen_next = gen_reg + DATA_BITS'(1);
    end
    // An all-zero LFSR never leaves zero, so it is replaced by 1.
    seed_load = (mode && seed == '0) ? DATA_BITS'(1) : seed;
    wc_inc    = word_count + COUNT_BITS'(1);
    // Pulses arriving in the handshake cycle still apply to the next loaded beat.
    abort_now = abort_pending | (abort & ~m_tlast);
    err_now   = err_pending | inject_error;
    last_next = ((length_reg != '0) && (wc_inc == length_reg - COUNT_BITS'(1))) || abort_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      length_reg    <= '0;
      gen_reg       <= '0;
      abort_pending <= 1'b0;
      err_pending   <= 1'b0;
      m_tvalid      <= 1'b0;
      m_tdata       <= '0;
      m_tlast       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      word_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg      <= mode;
            length_reg    <= length;
            gen_reg       <= seed_load;
            m_tdata       <= seed_load;
            m_tlast       <= (length == COUNT_BITS'(1));
            m_tvalid      <= 1'b1;
            busy          <= 1'b1;
            word_count    <= '0;
            abort_pending <= 1'b0;
            err_pending   <= 1'b0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            word_count    <= wc_inc;
            abort_pending <= 1'b0;
            err_pending   <= 1'b0;
            if (m_tlast) begin
              m_tvalid  <= 1'b0;
              m_tlast   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= IDLE;
            end else begin
              // The corruption is applied only to the output word, never to gen_reg.
              gen_reg <= gen_next;
              m_tdata <= gen_next ^ DATA_BITS'(err_now);
              m_tlast <= last_next;
            end
          end else begin
            abort_pending <= abort_now;
            err_pending   <= err_now;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_stream_pattern_gen.md
Name: axi_stream_pattern_gen

Overview:
Source-side companion to the stream comparator: generates a deterministic AXI-Stream test pattern (counter or Galois LFSR) with full tvalid/tready backpressure handling. Two instances with identical seeds feed both comparator inputs for loopback and link self-test. A one-shot error-injection pulse corrupts exactly one beat so the comparator's mismatch path can be exercised. Runs are bounded (length words) or free-running, can be stopped cleanly by abort, and are framed with tlast.

Parameters:
DATA_BITS, 32, width of m_tdata, seed and generator state
COUNT_BITS, 32, width of length and word_count
LFSR_TAPS, 32'h80200003, Galois feedback mask XORed in when the shifted-out bit is 1

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  pulse; begin a run (ignored while busy)
mode  in  1  sampled at start; 0 = counter, 1 = LFSR
seed  in  DATA_BITS  sampled at start; first word of the run
length  in  COUNT_BITS  sampled at start; beats per run, 0 = unbounded
abort  in  1  pulse; end the run early, with a clean tlast
inject_error  in  1  pulse; flip bit 0 of one future beat
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tdata  out  DATA_BITS  stream data, registered
m_tlast  out  1  final beat of the run, registered
busy  out  1  high from the cycle after start until the final handshake
done  out  1  one-cycle pulse after the final beat is accepted
word_count  out  COUNT_BITS  beats accepted in the current or last run

Behaviour:
- Reset is synchronous, active-high, on rst; clock is clk. All outputs go to 0 and state goes to IDLE. Reset mid-run drops m_tvalid on the next edge; no tlast is sent.
- States are IDLE and RUN. Handshake: hs = m_tvalid && m_tready.
- IDLE + start: latch mode and length, load the generator, clear word_count and pending flags, enter RUN.
  - On the following cycle: m_tvalid=1, m_tdata=seed, busy=1.
  - m_tlast=1 on that first beat if length==1.
- LFSR mode with seed==0: the generator loads 1 to avoid lock-up, so the first beat is 1.
- RUN:
  - m_tvalid stays 1 and m_tdata/m_tlast stay stable until hs.
  - On hs, word_count increments with wrap.
  - If the accepted beat had tlast=1: go to IDLE, m_tvalid=0, busy=0, done=1 for one cycle. word_count holds until the next start.
  - Otherwise: advance the generator and load the next beat.
- Generator advance:
  - Counter: state+1 mod 2^DATA_BITS.
  - LFSR: if state[0] then (state>>1)^LFSR_TAPS, else state>>1.
- tlast on the next loaded beat is set when either holds:
  - length!=0 and word_count+1==length-1, i.e. the next beat is number length;
  - abort_pending is set.
- abort:
  - In RUN, sets abort_pending. The beat currently presented is never altered; the next loaded beat carries tlast=1 and ends the run.
  - No effect if the presented beat already has tlast=1.
  - Ignored in IDLE.
- inject_error:
  - In RUN, sets err_pending. The next loaded beat is emitted as state^1 and err_pending clears.
  - Generator state is not corrupted, so the stream is correct again on the following beat.
  - The presented beat is never altered. Ignored in IDLE. A repeat pulse while pending has no extra effect.
- start while busy is ignored. start on the done cycle is accepted.
- Simultaneous abort and inject_error: both apply to the same next beat.
- An unbounded run ends only on abort or reset. Neither the generator state nor word_count saturates.

Test Plan:
1. Counter mode, seed=5, length=4, m_tready=1 constant -> beats 5,6,7,8 on consecutive cycles starting the cycle after start. tlast only on 8. done pulses the cycle after 8 is accepted. word_count=4, busy=0.
2. Same run with m_tready=1,0,0,1,0,1,1 -> m_tdata/m_tlast never change while m_tvalid=1 and m_tready=0. Accepted sequence is still 5,6,7,8.
3. LFSR mode, seed=1, length=3 -> 0x00000001, 0x80200003, 0xC0300002, tlast on the third. Repeat with seed=0 -> first beat 0x00000001.
4. Counter mode, seed=0, length=0. Pulse inject_error while beat 2 is presented -> accepted beats 0,1,2,2,4,5. This sequence is 3^1 followed by correct resumption.
5. Counter mode, length=0. Pulse abort while beat 7 is presented with m_tready=0 -> beat 7 held unchanged without tlast, then beat 8 carries tlast=1. done follows; word_count=9.
6. Pulse start during a run -> ignored, sequence unaffected. Assert rst mid-run -> next cycle m_tvalid=0, busy=0, done=0, word_count=0. A new start then restarts cleanly from seed.
